// File: rtl/slave_mem_if.sv
// Write-handshake bundle between the upstream interconnect and slave_mem.
interface slave_mem_if;
  logic       valid_in;
  logic [2:0] addr_in;
  logic [2:0] value_in;
  logic       ready_out;
  logic       hs_done;

  modport master (output valid_in, addr_in, value_in, input ready_out, hs_done);
  modport slave  (input valid_in, addr_in, value_in, output ready_out, hs_done);
endinterface

// File: rtl/slave_mem.sv
// 8x3 slave memory with valid/ready write handshake and registered readback.
// Optional feature: define SLAVE_WAIT_EN to insert wait_cfg wait cycles before ready.
module slave_mem #(
  parameter logic [2:0] INIT_VAL = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  slave_mem_if.slave  bus,
  input  logic [2:0]  wait_cfg,
  input  logic [2:0]  rd_addr,
  output logic [2:0]  rd_data,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] mem [8];
  logic       hs;

  assign bus.ready_out = (state == S_READY);
  assign hs            = bus.valid_in && bus.ready_out;

`ifdef SLAVE_WAIT_EN
  logic [2:0] wait_cnt;

  // Reloaded every idle cycle, so the value present on entry to S_WAIT is wait_cfg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_cnt <= '0;
    else if (state == S_IDLE)  wait_cnt <= wait_cfg;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt - 3'd1;
  end
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^wait_cfg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.valid_in) begin
`ifdef SLAVE_WAIT_EN
          state_nxt = (wait_cfg != '0) ? S_WAIT : S_READY;
`else
          state_nxt = S_READY;
`endif
        end
      end
      S_WAIT: begin
`ifdef SLAVE_WAIT_EN
        if (!bus.valid_in)          state_nxt = S_IDLE;
        else if (wait_cnt == 3'd1)  state_nxt = S_READY;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_READY: state_nxt = bus.valid_in ? S_DONE : S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) mem[i] <= INIT_VAL;
    end else if (hs) begin
      mem[bus.addr_in] <= bus.value_in;
    end
  end

  // Non-blocking read of the old array contents gives read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data     <= '0;
      wr_count    <= '0;
      bus.hs_done <= 1'b0;
    end else begin
      rd_data     <= mem[rd_addr];
      bus.hs_done <= hs;
      if (hs) wr_count <= wr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_slave_mem.sv
// Scoreboard bench for slave_mem: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_slave_mem;
  localparam logic [2:0] INIT = 3'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] wait_cfg = '0;
  logic [2:0] rd_addr = '0;
  logic [2:0] rd_data;
  logic [7:0] wr_count;

  slave_mem_if bus();

  slave_mem #(.INIT_VAL(INIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .wait_cfg (wait_cfg),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  val;
  } rd_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  hs_q[$];
  rd_t         rd_q[$];
  logic [7:0]  model_cnt = '0;
  logic [2:0]  mem_m [8];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.hs_done) begin
        if (hs_q.size() == 0) begin
          check("hs_done_unexpected", 1, 0);
        end else begin
          logic [7:0] e;
          e = hs_q.pop_front();
          check("wr_count", wr_count, e);
        end
      end
      while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        rd_t r;
        r = rd_q.pop_front();
        check("rd_data", rd_data, r.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    model_cnt = '0;
    for (int i = 0; i < 8; i++) mem_m[i] = INIT;
  endtask

  task automatic read_chk(input logic [2:0] a);
    rd_t r;
    rd_addr = a;
    r.cyc = cyc + 1;
    r.val = mem_m[a];
    rd_q.push_back(r);
    tick();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [2:0] v, input bit rbw);
    int unsigned lat;
    int unsigned exp_lat;
    bit got;
    rd_t r;
`ifdef SLAVE_WAIT_EN
    exp_lat = (wait_cfg != '0) ? int'(wait_cfg) + 1 : 1;
`else
    exp_lat = 1;
`endif
    bus.addr_in  = a;
    bus.value_in = v;
    bus.valid_in = 1'b1;
    if (rbw) rd_addr = a;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.ready_out) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    if (!got) begin
      check("ready_timeout", 0, 1);
      bus.valid_in = 1'b0;
      tick();
      return;
    end
    check("ready_latency", lat, exp_lat);
    model_cnt = model_cnt + 8'd1;
    hs_q.push_back(model_cnt);
    if (rbw) begin
      r.cyc = cyc + 1; r.val = mem_m[a]; rd_q.push_back(r);
      r.cyc = cyc + 2; r.val = v;        rd_q.push_back(r);
    end
    mem_m[a] = v;
    tick();
    bus.valid_in = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.addr_in  = '0;
    bus.value_in = '0;
    reset_model();
    #1;
    check("rst_ready", bus.ready_out, 0);
    check("rst_hs_done", bus.hs_done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_count", wr_count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    read_chk(3'd0);
    read_chk(3'd7);

    // single write then readback
    do_write(3'd5, 3'd6, 1'b0);
    read_chk(3'd5);
    tick();

    // withdraw after one cycle in S_READY
    bus.addr_in  = 3'd4;
    bus.value_in = 3'd1;
    bus.valid_in = 1'b1;
    tick();
    check("withdraw_ready", bus.ready_out, 1);
    bus.valid_in = 1'b0;
    tick();
    check("withdraw_ready_low", bus.ready_out, 0);
    tick();
    check("withdraw_wr_count", wr_count, model_cnt);
    read_chk(3'd4);

    // read-before-write on the same address
    do_write(3'd2, 3'd1, 1'b0);
    do_write(3'd2, 3'd4, 1'b1);
    tick();

`ifdef SLAVE_WAIT_EN
    wait_cfg = 3'd3;
    do_write(3'd6, 3'd5, 1'b0);
    wait_cfg = 3'd0;
    do_write(3'd6, 3'd2, 1'b0);
    read_chk(3'd6);
`endif

    // reset while ready_out and valid_in are both high
    bus.addr_in  = 3'd1;
    bus.value_in = 3'd7;
    bus.valid_in = 1'b1;
    tick();
    check("midrst_ready_before", bus.ready_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.ready_out, 0);
    check("midrst_hs_done", bus.hs_done, 0);
    check("midrst_wr_count", wr_count, 0);
    check("midrst_rd_data", rd_data, 0);
    reset_model();
    bus.valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_hs_after", bus.hs_done, 0);
    read_chk(3'd1);
    read_chk(3'd5);

    // 256 writes: count passes 255 then wraps to 0
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      do_write(iv[2:0], iv[5:3], 1'b0);
    end
    tick();
    check("wrap_wr_count", wr_count, 0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      read_chk(iv[2:0]);
    end

    repeat (3) tick();
    check("hs_pending", hs_q.size(), 0);
    check("rd_pending", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slave_mem.md
SLAVE_MEM -- requirements
Module: slave_mem

Interface
REQ-001 The block SHALL have parameter INIT_VAL, default 3'd0, meaning the value loaded into every storage entry at reset.
REQ-002 The block SHALL have port clk, input, 1, sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port valid_in, input, 1, upstream interconnect asserts a pending write.
REQ-005 The block SHALL have port addr_in, input, 3, write address, stable while valid_in is high.
REQ-006 The block SHALL have port value_in, input, 3, write data, stable while valid_in is high.
REQ-007 The block SHALL have port wait_cfg, input, 3, extra wait cycles before ready; used only when SLAVE_WAIT_EN is defined.
REQ-008 The block SHALL have port rd_addr, input, 3, readback address.
REQ-009 The block SHALL have port ready_out, output, 1, slave accepts the write this cycle.
REQ-010 The block SHALL have port hs_done, output, 1, registered one-cycle pulse marking a completed handshake.
REQ-011 The block SHALL have port rd_data, output, 3, registered readback data.
REQ-012 The block SHALL have port wr_count, output, 8, count of completed writes.

Function
REQ-013 The storage SHALL be 8 entries x 3 bits, indexed by addr_in.
REQ-014 The FSM SHALL have states S_IDLE, S_WAIT, S_READY and S_DONE; ready_out SHALL be high only in S_READY.
REQ-015 In S_IDLE, if valid_in is sampled high, the next state SHALL be S_READY, or S_WAIT per REQ-028; otherwise the FSM SHALL stay in S_IDLE.
REQ-016 A handshake SHALL be defined as valid_in && ready_out at a rising edge.
REQ-017 On a handshake, mem[addr_in] SHALL take value_in at that edge, and the next state SHALL be S_DONE.
REQ-018 On a handshake, wr_count SHALL increment at that edge, wrapping from 255 to 0.
REQ-019 hs_done SHALL be high exactly in the cycle after each handshake, which is the S_DONE cycle.
REQ-020 S_DONE SHALL last one cycle with ready_out low, then go to S_IDLE, so back-to-back writes are spaced by at least 3 cycles.
REQ-021 If valid_in falls in S_WAIT or S_READY without a handshake, the FSM SHALL return to S_IDLE with no write, no hs_done and no change to wr_count.
REQ-022 rd_data SHALL take mem[rd_addr] at every rising edge, giving 1-cycle read latency.
REQ-023 When a write and a read target the same address at the same edge, rd_data SHALL return the pre-write value (read-before-write).
REQ-024 With SLAVE_WAIT_EN undefined, write latency SHALL be: valid_in high at edge N, ready_out high in cycle N+1, write at edge N+1.

Reset
REQ-025 While rst_n is low, the state SHALL be S_IDLE, ready_out 0, hs_done 0, rd_data 0, wr_count 0, and every mem entry INIT_VAL, all asynchronously.
REQ-026 A reset asserted in any state, including S_READY with valid_in high, SHALL abort the transaction with no write.
REQ-027 After rst_n deasserts, the first valid_in sample SHALL occur at the next rising edge.

Configuration
REQ-028 With macro SLAVE_WAIT_EN defined, S_IDLE SHALL go to S_WAIT when valid_in is high and wait_cfg != 0.
REQ-029 With SLAVE_WAIT_EN defined, the FSM SHALL hold S_WAIT for exactly wait_cfg cycles, counted by a 3-bit down-counter loaded on entry, then go to S_READY.
REQ-030 With SLAVE_WAIT_EN defined and wait_cfg = 0, the behaviour SHALL be identical to REQ-024.
REQ-031 With SLAVE_WAIT_EN undefined, S_WAIT SHALL be unreachable, wait_cfg SHALL be ignored, and no wait counter SHALL be built.

Verification
REQ-032 Single write: reset, then valid_in=1, addr_in=5, value_in=6 -> ready_out=1 in the next cycle; then hs_done=1 for one cycle, wr_count=1, and rd_addr=5 gives rd_data=6 one cycle later.
REQ-033 Withdraw: valid_in high for one cycle only (S_IDLE->S_READY), then low -> no write, hs_done stays 0, wr_count=0, mem[addr] still INIT_VAL.
REQ-034 Read-before-write: mem[2]=1, then write 4 to address 2 with rd_addr=2 at the handshake edge -> rd_data=1 on that edge and 4 on the next.
REQ-035 Wrap: 256 consecutive writes -> wr_count reads 255 after write 255 and 0 after write 256; the minimum spacing of 3 cycles per write is met.
REQ-036 Wait (SLAVE_WAIT_EN defined): wait_cfg=3, valid_in held high from edge N -> ready_out first high in cycle N+4; with wait_cfg=0, ready_out is high in cycle N+1.
REQ-037 Reset mid-transaction: rst_n pulled low while ready_out=1 and valid_in=1 -> ready_out=0 immediately, no write, and all outputs hold their reset values.
